serial_parity_rx: RTL and testbench
===================================

Name: serial_parity_rx

Overview:
Serial-to-parallel receiver for 9-bit parity frames: DATA_W data bits plus one parity bit, the same frame format the nine-bit parity generator produces.
- Shifts bits in one at a time and checks parity over the whole frame.
- Presents the data word with an error flag through a one-deep valid/ready output slot.
- Sits directly downstream of the parity generator / serial link and feeds the byte consumer.

Parameters:
DATA_W, 8, number of data bits per frame; frame length is DATA_W+1.
PARITY_ODD, 0, 0 = even parity expected (XOR of all frame bits = 0); 1 = odd parity expected (XOR = 1).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
sin_valid  input  1  sin_bit is valid this cycle; sampled on the rising edge.
sin_bit  input  1  serial bit; data LSB first, parity bit last.
sclr  input  1  synchronous abort; discards the partial frame.
out_data  output  DATA_W  received data word.
out_par_err  output  1  parity check failed for out_data.
out_valid  output  1  output slot holds a frame.
out_ready  input  1  consumer accepts the frame when out_valid && out_ready.
busy  output  1  a partial frame is in progress (bit count nonzero).
overrun  output  1  one-cycle pulse: a completed frame was dropped because the slot was full.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, bit_cnt=0, shift register=0.
  - out_data=0, out_par_err=0, out_valid=0, busy=0, overrun=0.
  - Reset mid-frame discards the partial frame and any frame held in the slot.
- States:
  - IDLE: bit_cnt=0.
    - sin_valid=1 → capture bit 0, go to SHIFT, bit_cnt=1.
  - SHIFT: each sin_valid=1 captures the bit at index bit_cnt and increments bit_cnt.
    - When the bit at index DATA_W (parity) is captured, the frame completes; return to IDLE with bit_cnt=0.
    - sin_valid=0 holds state; there is no timeout.
- busy = (state==SHIFT), registered.
- Parity:
  - p = XOR of the DATA_W data bits and the parity bit.
  - par_err = p XOR PARITY_ODD, i.e. an error when p differs from the expected value.
- Output slot:
  - On the completing edge, out_data, out_par_err and out_valid=1 are registered together, so out_valid rises in the cycle after the parity bit is sampled.
  - Latency is 1 cycle from the parity-bit edge.
  - out_valid stays high and out_data/out_par_err stay stable until a handshake (out_valid && out_ready at a rising edge).
- Simultaneous events:
  - Completion and handshake on the same edge: the slot is refilled with the new frame and out_valid stays 1.
  - Completion while the slot is full and out_ready=0: the new frame is dropped, the slot is unchanged, and overrun=1 for exactly one cycle.
  - Handshake with no completion: out_valid=0 next cycle; out_data keeps its last value.
- sclr:
  - Returns the FSM to IDLE with bit_cnt=0 and drops the partial frame.
  - Does not clear the output slot.
  - sclr has priority over a sin_valid in the same cycle (that bit is discarded).
- Arithmetic:
  - bit_cnt has width clog2(DATA_W+1).
  - It never exceeds DATA_W; there is no wrap except the reset to 0 on completion.

Optional Feature:
Macro SERIAL_PARITY_RX_DROP_ERR_EN.
- Defined: frames with par_err=1 are never written to the slot, out_valid is not raised, and an extra output err_pulse (1 bit) pulses for one cycle on the completing edge. A dropped errored frame never triggers overrun. out_par_err is tied to 0.
- Undefined: errored frames are delivered with out_par_err=1 and no err_pulse port exists.

Decomposition:
- Package serial_parity_pkg:
  - localparams for DATA_W, the frame length, and the counter width.
  - FSM state enum {IDLE, SHIFT}.
  - PARITY_EVEN/PARITY_ODD constants.
- One natural sub-module: parity_calc9, a combinational XOR reduction over the 9-bit frame with a PARITY_ODD parameter producing the error flag. It is reusable by the upstream generator bench.

Test Plan:
- Even parity, out_ready=1: send 0xA5 LSB first plus parity 0 → out_valid 1 cycle after the 9th bit, out_data=0xA5, out_par_err=0.
- Same frame with parity bit 1 → out_data=0xA5, out_par_err=1; with DROP_ERR_EN, out_valid stays 0 and err_pulse=1 for one cycle.
- out_ready=0, two back-to-back good frames 0x01 then 0x03 → out_data stays 0x01, overrun pulses once at the second completion; raise out_ready → handshake, out_valid drops.
- Completion and handshake on the same edge: frame 0x10 held, 0x20 completes while out_ready=1 → next cycle out_valid=1, out_data=0x20, no overrun.
- Abort and reset mid-frame:
  - Send 4 bits, assert sclr → busy=0; a full new frame 0x7F then decodes correctly.
  - Send 5 bits, pulse rst_n low asynchronously → all outputs 0 immediately.
- PARITY_ODD=1: frame 0x00 with parity 1 → out_par_err=0; frame 0x00 with parity 0 → out_par_err=1.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity receiver.
// Default frame geometry, parity-mode constants and the FSM state enum.
package serial_parity_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int FRAME_W_DEF = DATA_W_DEF + 1;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  // Counter must hold 0..dw, so it needs clog2(dw+1) bits.
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/parity_calc9.sv
// Combinational parity checker over a full frame (data + parity bit).
// Ports: frame_i (W bits), par_err_o (1 = frame XOR differs from PARITY_ODD).
module parity_calc9
  import serial_parity_pkg::*;
#(
  parameter int W          = FRAME_W_DEF,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input  logic [W-1:0] frame_i,
  output logic         par_err_o
);

  assign par_err_o = (^frame_i) ^ PARITY_ODD;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial-to-parallel parity frame receiver with a one-deep valid/ready slot.
// Ports: clk, rst_n, sin_valid/sin_bit/sclr in; out_data/out_par_err/out_valid,
// out_ready in, busy, overrun out. Option SERIAL_PARITY_RX_DROP_ERR_EN drops
// errored frames and adds err_pulse.
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin_valid,
  input  logic              sin_bit,
  input  logic              sclr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
  output logic              err_pulse,
`endif
  output logic              overrun
);

  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);
  localparam bit ODD = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W:0]   sh_cat;
  logic              done;
  logic              perr;

  logic [DATA_W-1:0] dat_q, dat_d;
  logic              val_q, val_d;
  logic              ovr_q, ovr_d;
  logic              keep;
  logic              wr;

  // New bits enter at the MSB; after DATA_W shifts bit 0 sits at the LSB.
  assign sh_cat = {sin_bit, sh_q};

  parity_calc9 #(
    .W          (DATA_W + 1),
    .PARITY_ODD (ODD)
  ) u_par (
    .frame_i   ({sin_bit, sh_q}),
    .par_err_o (perr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done    = 1'b0;
    if (sclr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
    end else if (sin_valid) begin
      unique case (state_q)
        IDLE: begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(1);
          sh_d    = sh_cat[DATA_W:1];
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            sh_d  = sh_cat[DATA_W:1];
          end
        end
      endcase
    end
  end

`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
  logic epul_q, epul_d;

  assign keep   = done & ~perr;
  assign epul_d = done & perr;
`else
  logic perr_q, perr_d;

  assign keep = done;
`endif

  // A completed frame lands only if the slot is empty or emptying now.
  assign wr    = keep & (~val_q | out_ready);
  assign ovr_d = keep & val_q & ~out_ready;
  assign val_d = wr | (val_q & ~out_ready);
  assign dat_d = wr ? sh_q : dat_q;
`ifndef SERIAL_PARITY_RX_DROP_ERR_EN
  assign perr_d = wr ? perr : perr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dat_q   <= '0;
      val_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
      epul_q  <= 1'b0;
`else
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      val_q   <= val_d;
      ovr_q   <= ovr_d;
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
      epul_q  <= epul_d;
`else
      perr_q  <= perr_d;
`endif
    end
  end

  assign out_data  = dat_q;
  assign out_valid = val_q;
  assign busy      = (state_q == SHIFT);
  assign overrun   = ovr_q;
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
  assign out_par_err = 1'b0;
  assign err_pulse   = epul_q;
`else
  assign out_par_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx (even DUT plus an odd-parity DUT).
// Scoreboard holds {par_err, data} pushed at frame completion, popped on handshake.
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_bit = 1'b0;
  logic       sclr = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data, o_data;
  logic       out_par_err, out_valid, busy, overrun;
  logic       o_par_err, o_valid, o_busy, o_ovr;
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
  logic       err_pulse, o_err_pulse;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .sclr(sclr), .out_data(out_data), .out_par_err(out_par_err),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
    .err_pulse(err_pulse),
`endif
    .overrun(overrun)
  );

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .sclr(sclr), .out_data(o_data), .out_par_err(o_par_err),
    .out_valid(o_valid), .out_ready(out_ready), .busy(o_busy),
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
    .err_pulse(o_err_pulse),
`endif
    .overrun(o_ovr)
  );

  task automatic cyc(input logic v, input logic b, input logic c,
                     input logic r);
    logic [8:0] e;
    sin_valid = v;
    sin_bit   = b;
    sclr      = c;
    out_ready = r;
    if (out_valid === 1'b1 && r) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got %h/%b required no frame",
                 out_data, out_par_err);
      end else begin
        e = sb.pop_front();
        if ({out_par_err, out_data} !== e) begin
          n_bad++;
          $display("FAIL sb_frame: got err=%b data=%h required err=%b data=%h",
                   out_par_err, out_data, e[8], e[7:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic r, input logic lr,
                            input logic full);
    logic err;
    logic st;
    for (int i = 0; i < 8; i++) cyc(1'b1, d[i], 1'b0, r);
    err = (^d) ^ p;
    st  = !full;
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
    if (err) st = 1'b0;
`endif
    if (st) sb.push_back({err, d});
    cyc(1'b1, p, 1'b0, lr);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({out_data, out_par_err, out_valid, busy, overrun} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h %b %b %b %b required all 0",
               out_data, out_par_err, out_valid, busy, overrun);
    end
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
    n_cmp++;
    if (err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_errp: got %b required 0", err_pulse);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL good_latency: got out_valid=%b required 1", out_valid);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL good_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_bad_parity;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
    n_cmp++;
    if (out_valid !== 1'b0 || err_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_drop: got valid=%b errp=%b required 0/1",
               out_valid, err_pulse);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_errp_len: got %b required 0", err_pulse);
    end
`else
    n_cmp++;
    if (out_valid !== 1'b1 || out_par_err !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_flag: got valid=%b err=%b required 1/1",
               out_valid, out_par_err);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_overrun;
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (overrun !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h01) begin
      n_bad++;
      $display("FAIL ovr_pulse: got ovr=%b valid=%b data=%h required 1/1/01",
               overrun, out_valid, out_data);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (overrun !== 1'b0 || out_data !== 8'h01) begin
      n_bad++;
      $display("FAIL ovr_once: got ovr=%b data=%h required 0/01",
               overrun, out_data);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h01) begin
      n_bad++;
      $display("FAIL ovr_drain: got valid=%b data=%h required 0/01",
               out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h20, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || overrun !== 1'b0 || out_data !== 8'h20) begin
      n_bad++;
      $display("FAIL b2b_refill: got valid=%b ovr=%b data=%h required 1/0/20",
               out_valid, overrun, out_data);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_sclr;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL sclr_busy_pre: got %b required 1", busy);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sclr_busy_post: got %b required 0", busy);
    end
    send_frame(8'h7F, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL sclr_next: got valid=%b required 1", out_valid);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: got busy=%b valid=%b required 1/1",
               busy, out_valid);
    end
    sin_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_data, out_par_err, out_valid, busy, overrun} !== 12'h0) begin
      n_bad++;
      $display("FAIL arst_now: got %h %b %b %b %b required all 0",
               out_data, out_par_err, out_valid, busy, overrun);
    end
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_odd_parity;
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_par_err !== 1'b0) begin
      n_bad++;
      $display("FAIL odd_good: got valid=%b err=%b required 1/0",
               o_valid, o_par_err);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef SERIAL_PARITY_RX_DROP_ERR_EN
    n_cmp++;
    if (o_valid !== 1'b0 || o_err_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL odd_bad: got valid=%b errp=%b required 0/1",
               o_valid, o_err_pulse);
    end
`else
    n_cmp++;
    if (o_valid !== 1'b1 || o_par_err !== 1'b1) begin
      n_bad++;
      $display("FAIL odd_bad: got valid=%b err=%b required 1/1",
               o_valid, o_par_err);
    end
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_parity();
    test_overrun();
    test_back_to_back();
    test_sclr();
    test_async_reset();
    test_odd_parity();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
